// File: rtl/enc_dec_arbiter_pkg.sv
// Shared definitions for the EncDec round-robin arbiter: default sizes,
// FSM state encoding and a constant clog2 helper for parameter math.
package enc_dec_arbiter_pkg;

  // Ceiling log2 usable in parameter defaults (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int DEF_N        = 8;
  localparam int DEF_IDXW     = 3;
  localparam int DEF_CNTW     = 8;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/enc_dec_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request bit scanning upward from
// last_ptr+1 (wrapping at N). Rotate so that bit 0 is the highest-priority
// slot, priority-encode the lowest set bit, then un-rotate the offset.
module rr_pick
  import enc_dec_arbiter_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int IDXW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last_ptr,
  output logic [IDXW-1:0] pick,
  output logic            any_req
);

  logic [IDXW-1:0] start;
  logic [2*N-1:0]  doubled;
  logic [N-1:0]    rotated;
  logic [IDXW-1:0] offset;
  logic [IDXW:0]   sum;

  // Rotate, priority-encode and map the winner back to a requester index.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
    start  = '0;
    offset = '0;
    if (last_ptr != IDXW'(N - 1)) start = last_ptr + 1'b1;
    doubled = {req, req};
    rotated = N'(doubled >> start);
    // Scan downward so the lowest set bit is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDXW'(i);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (IDXW + 1)'(N)) sum = sum - (IDXW + 1)'(N);
    pick    = sum[IDXW-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/enc_dec_arbiter.sv
// Round-robin arbiter sharing the one-hot EncDec datapath between N
// requesters. A grant is held until done or the owner drops its request,
// followed by at least one idle cycle before the next grant.
// Optional watchdog: define ARB_TIMEOUT_EN to revoke grants held for
// MAX_HOLD cycles and pulse timeout; otherwise timeout stays 0.
module enc_dec_arbiter
  import enc_dec_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDXW     = clog2(N),
  parameter int CNTW     = DEF_CNTW
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic [CNTW-1:0] grant_cnt,
  output logic            timeout
);

  localparam logic [N-1:0] ONE_HOT0 = {{(N - 1){1'b0}}, 1'b1};

  state_t          state, state_next;
  logic [IDXW-1:0] last_ptr, last_ptr_next;
  logic [IDXW-1:0] pick;
  logic            any_req;
  logic            release_now;
  logic            expire;

  logic [N-1:0]    grant_next;
  logic [IDXW-1:0] grant_idx_next;
  logic            grant_valid_next;
  logic [CNTW-1:0] grant_cnt_next;
  logic            timeout_next;

  rr_pick #(.N(N), .IDXW(IDXW)) u_rr_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .pick     (pick),
    .any_req  (any_req)
  );

  // Owner finished or walked away; only meaningful in ST_GRANT.
  assign release_now = done | ~req[grant_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLDW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
  logic [HOLDW-1:0] hold_cnt;

  // Watchdog: zero while idle, so it reads 0 on the first grant cycle.
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE) hold_cnt <= '0;
    else                           hold_cnt <= hold_cnt + 1'b1;
  end

  assign expire = (state == ST_GRANT) && (hold_cnt == HOLDW'(MAX_HOLD - 1));
`else
  assign expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (any_req)               state_next = ST_GRANT;
      ST_GRANT: if (release_now || expire) state_next = ST_IDLE;
      default:                             state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the priority pointer.
  always_comb begin
    grant_next       = grant;
    grant_idx_next   = grant_idx;
    grant_valid_next = grant_valid;
    grant_cnt_next   = grant_cnt;
    last_ptr_next    = last_ptr;
    timeout_next     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_next       = ONE_HOT0 << pick;
          grant_idx_next   = pick;
          grant_valid_next = 1'b1;
          grant_cnt_next   = grant_cnt + 1'b1;
        end
      end
      ST_GRANT: begin
        if (release_now || expire) begin
          grant_next       = '0;
          grant_valid_next = 1'b0;
          last_ptr_next    = grant_idx;
          timeout_next     = expire & ~release_now;
        end
      end
      default: ;
    endcase
  end

  // Output and pointer registers; priority restarts at requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      grant_cnt   <= '0;
      timeout     <= 1'b0;
      last_ptr    <= IDXW'(N - 1);
    end else begin
      grant       <= grant_next;
      grant_idx   <= grant_idx_next;
      grant_valid <= grant_valid_next;
      grant_cnt   <= grant_cnt_next;
      timeout     <= timeout_next;
      last_ptr    <= last_ptr_next;
    end
  end

endmodule

// File: doc/enc_dec_arbiter.md
Name: enc_dec_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit one-hot EncDec datapath between 8 requesters.
- Registered one-hot grant drives the EncDec 8-bit input directly; the binary grant index travels alongside it.
- Holds each grant until the owner signals done or drops its request, then rotates priority.
- Keeps a wrapping count of issued grants for debug/status.

Parameters:
N, 8, number of requesters (one-hot width; must match EncDec width)
IDXW, 3, grant index width, equals clog2(N)
CNTW, 8, width of the grant counter
MAX_HOLD, 16, watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  N  request per requester, level, held until served
done  input  1  one-cycle pulse from current owner: transaction complete
grant  output  N  registered one-hot grant, all-zero when idle; feeds EncDec In
grant_idx  output  IDXW  binary index of granted requester
grant_valid  output  1  high while any grant is held
grant_cnt  output  CNTW  total grants issued, wraps
timeout  output  1  one-cycle pulse on watchdog revoke (ties 0 when feature is out)

Behaviour:
- One clock; reset is synchronous and active-high; all outputs are registered.
- Reset values:
  - grant=0, grant_idx=0, grant_valid=0, grant_cnt=0, timeout=0
  - state=IDLE
  - last_ptr=N-1, so requester 0 has top priority after reset
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit scanning last_ptr+1, last_ptr+2, … modulo N.
  - Next edge: grant=onehot(pick), grant_idx=pick, grant_valid=1, grant_cnt+=1, state=GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- GRANT, hold:
  - Grant stays stable while req[grant_idx]=1 and done=0.
  - Requests from other requesters are ignored.
- GRANT, release:
  - Triggered by done=1 or req[grant_idx]=0.
  - Next edge: grant=0, grant_valid=0, last_ptr=grant_idx, state=IDLE.
  - grant_idx keeps its last value.
- There is always at least one idle cycle between consecutive grants; a grant is never handed over back-to-back.
- Simultaneous release and new requests: release wins; arbitration happens in the following IDLE cycle using the updated last_ptr.
- Releasing requester still requesting in IDLE: it has lowest priority. It is re-granted only if no other bit of req is set.
- done while in IDLE: ignored, no state change.
- grant_cnt wraps 2^CNTW-1 -> 0 with no flag.
- reset asserted mid-grant: grant drops to 0 at that edge; priority returns to requester 0.
- req bits asserted and dropped within one IDLE cycle can still be granted. The owner then releases by dropping req (1 grant cycle).

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 without a release, the next edge revokes the grant exactly like a release and pulses timeout=1 for one cycle.
  - A release on the same cycle takes precedence: no timeout pulse.
- Undefined: no hold counter; grants are held indefinitely; timeout is tied to 0.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - defaults for N, IDXW, CNTW, MAX_HOLD
  - the clog2 helper function
- One combinational sub-module, rr_pick:
  - inputs: req, last_ptr
  - outputs: pick index, any_req
  - implemented as rotate, priority-encode, un-rotate
- Arbiter FSM, counters and output registers stay in enc_dec_arbiter.

Test Plan:
- Reset, then req=8'b0000_0001 -> one cycle later grant=8'h01, grant_idx=0, grant_valid=1, grant_cnt=1; done pulse -> grant=0 next cycle.
- req=8'hFF held, done pulsed each grant -> grant sequence 01,02,04,…,80,01 with one idle cycle between each; grant_cnt=9 after nine grants.
- Owner idx 3 holds; req[5] rises mid-grant -> grant stays 8'h08; after done, next grant is 8'h20.
- req=8'h08 only, done pulsed -> re-grant 8'h08 after one idle cycle (sole requester keeps winning).
- Owner idx 6 granted; reset asserted -> grant=0, grant_cnt=0 at that edge; req=8'h41 afterward -> grant=8'h01 (priority back to 0).
- ARB_TIMEOUT_EN, MAX_HOLD=16: req=8'h04 held, no done -> grant drops after 16 GRANT cycles with timeout=1 for one cycle; done on cycle 16 -> no timeout pulse.
